// File: rtl/act_pack_writer_pkg.sv
// Shared accelerator definitions for the activation pack writer:
// default geometry and the job state encoding.
package act_pack_writer_pkg;

  localparam int APW_DATA_W     = 18;  // signed Q9 activation width
  localparam int APW_PACK       = 2;   // activations per memory word
  localparam int APW_FIFO_DEPTH = 16;  // input buffer entries, power of two
  localparam int APW_ADDR_W     = 16;  // word address / activation count width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } apw_state_t;

  // A job is in progress while receiving or draining the last words.
  function automatic logic state_is_busy(input apw_state_t s);
    return (s == ST_RUN) || (s == ST_FLUSH);
  endfunction

endpackage

// File: rtl/act_pack_writer_if.sv
// Bundle of job control, activation input, memory write and status
// signals for act_pack_writer.
//
// Memory handshake: a word transfers on a rising clk edge where mem_we and
// mem_ready are both high. Once mem_we rises, mem_addr and mem_wdata stay
// stable and mem_we stays high until that transfer; mem_we never depends
// combinationally on mem_ready. The activation input has no ready: an
// in_valid cycle is either taken or discarded by the writer.
interface act_pack_writer_if
  import act_pack_writer_pkg::*;
#(
  parameter int DATA_W = APW_DATA_W,
  parameter int PACK   = APW_PACK,
  parameter int ADDR_W = APW_ADDR_W
);

  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W-1:0]        num_vals;
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W*PACK-1:0]   mem_wdata;
  logic                     mem_ready;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  apw_state_t               state;     // debug view of the job FSM

  // Controller / memory side.
  modport master (
    output start, base_addr, num_vals, in_data, in_valid, mem_ready,
    input  mem_we, mem_addr, mem_wdata, busy, done, overflow, state
  );

  // The writer itself.
  modport slave (
    input  start, base_addr, num_vals, in_data, in_valid, mem_ready,
    output mem_we, mem_addr, mem_wdata, busy, done, overflow, state
  );

endinterface

// File: rtl/act_pack_writer_fifo.sv
// act_fifo: synchronous FIFO with single-entry push and a read window of
// RD_N entries from the head; pop_n removes 0..RD_N entries per cycle.
// A push while full succeeds when the same cycle pops at least one entry.
module act_fifo #(
  parameter  int W     = 18,
  parameter  int DEPTH = 16,
  parameter  int RD_N  = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  output logic             push_ok,
  input  logic [CW-1:0]    pop_n,
  output logic [CW-1:0]    count,
  output logic [RD_N*W-1:0] rd_win
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  assign push_ok = push && ((cnt_q != DEPTH_C) || (pop_n != '0));
  assign count   = cnt_q;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clr empties the buffer at job start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr + AW'(pop_n);
      cnt_q  <= cnt_q + CW'(push_ok) - pop_n;
    end
  end

  // Head window: lane k is the k-th oldest entry (wraps with the pointer).
  always_comb begin
    rd_win = '0;
    for (int k = 0; k < RD_N; k++) begin
      rd_win[k*W +: W] = mem[rd_ptr + AW'(k)];
    end
  end

endmodule

// File: rtl/act_pack_writer.sv
// Activation pack writer: buffers a stream of activations, packs PACK of
// them per memory word (first-received in lane 0) and writes the words to
// consecutive addresses from base_addr. A short final word is zero-padded.
module act_pack_writer
  import act_pack_writer_pkg::*;
#(
  parameter int DATA_W     = APW_DATA_W,
  parameter int PACK       = APW_PACK,
  parameter int FIFO_DEPTH = APW_FIFO_DEPTH,
  parameter int ADDR_W     = APW_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  act_pack_writer_if.slave bus
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int WORD_W = DATA_W * PACK;
  localparam logic [CNT_W-1:0] PACK_C = CNT_W'(PACK);

  apw_state_t        state_q;
  apw_state_t        state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] num_q;
  logic [ADDR_W-1:0] recv_q;
  logic [ADDR_W-1:0] word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic              overflow_q;

  logic              busy_c;
  logic              done_c;
  logic              start_ok;
  logic              accept;
  logic              xfer;
  logic              reg_free;
  logic              load_full;
  logic              load_part;
  logic              load;
  logic              push_ok;
  logic              drop;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  pop_n;
  logic [WORD_W-1:0] fifo_win;
  logic [WORD_W-1:0] load_word;

  // A start only counts in IDLE; values only count in RUN until the job
  // has received num_vals of them (dropped ones included).
  assign start_ok = (state_q == ST_IDLE) && bus.start;
  assign accept   = (state_q == ST_RUN) && bus.in_valid && (recv_q < num_q);
  assign drop     = accept && !push_ok;

  // The output register can take a new word when empty or emptying now.
  assign xfer      = we_q && bus.mem_ready;
  assign reg_free  = !we_q || xfer;
  assign load_full = busy_c && (fifo_cnt >= PACK_C) && reg_free;
  assign load_part = (state_q == ST_FLUSH) && (fifo_cnt != '0) &&
                     (fifo_cnt < PACK_C) && reg_free;
  assign load      = load_full || load_part;
  assign pop_n     = load_full ? PACK_C : (load_part ? fifo_cnt : '0);

  act_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .RD_N  (PACK)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .push      (accept),
    .push_data (bus.in_data),
    .push_ok   (push_ok),
    .pop_n     (pop_n),
    .count     (fifo_cnt),
    .rd_win    (fifo_win)
  );

  // Lane assembly: lanes beyond the buffered count are zero-filled.
  always_comb begin
    load_word = '0;
    for (int k = 0; k < PACK; k++) begin
      if (CNT_W'(k) < fifo_cnt) begin
        load_word[k*DATA_W +: DATA_W] = fifo_win[k*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: FLUSH ends once the buffer is empty and the last word
  // has left the output register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = (bus.num_vals == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (recv_q == num_q) state_d = ST_FLUSH;
      ST_FLUSH: if ((fifo_cnt == '0) && reg_free) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_c = state_is_busy(state_q);
    done_c = (state_q == ST_DONE);
  end

  // Job parameters and received-value counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q <= '0;
      num_q  <= '0;
      recv_q <= '0;
    end else if (start_ok) begin
      base_q <= bus.base_addr;
      num_q  <= bus.num_vals;
      recv_q <= '0;
    end else if (accept) begin
      recv_q <= recv_q + ADDR_W'(1);
    end
  end

  // Sticky overflow: set by a drop, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          overflow_q <= 1'b0;
    else if (start_ok) overflow_q <= 1'b0;
    else if (drop)     overflow_q <= 1'b1;
  end

  // Output word register and word index; held until the transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else if (load) begin
      we_q    <= 1'b1;
      addr_q  <= base_q + word_q;
      wdata_q <= load_word;
      word_q  <= word_q + ADDR_W'(1);
    end else begin
      if (xfer)     we_q   <= 1'b0;
      if (start_ok) word_q <= '0;
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.overflow  = overflow_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_act_pack_writer.sv
// Bench for act_pack_writer: directed jobs plus randomized jobs, with the
// expected memory writes computed from the activation lists by a packing
// model and consumed by a write monitor.
module tb_act_pack_writer;
  import act_pack_writer_pkg::*;

  localparam int DW = APW_DATA_W;
  localparam int PK = APW_PACK;
  localparam int FD = APW_FIFO_DEPTH;
  localparam int AW = APW_ADDR_W;
  localparam int WW = DW * PK;
  localparam int EW = AW + WW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  act_pack_writer_if #(.DATA_W(DW), .PACK(PK), .ADDR_W(AW)) bus ();

  act_pack_writer #(
    .DATA_W(DW), .PACK(PK), .FIFO_DEPTH(FD), .ADDR_W(AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];
  int model_vals[$];
  int stim_vals[$];
  int exp_words;

  int xfer_cnt, extra_writes, first_xfer_cyc, last_xfer_cyc;
  int first_we_cyc, done_cnt, done_cyc, done_base, val_cyc;
  bit we_seen, busy_seen;
  int ready_mode;  // 0: held by main, 1: random

  // Pack the accepted activations in arrival order, PK per word, zero pad,
  // addresses counting up from base modulo 2^AW.
  function automatic void build_expect(input logic [AW-1:0] base);
    int n = model_vals.size();
    exp_words = (n + PK - 1) / PK;
    for (int w = 0; w < exp_words; w++) begin
      logic [WW-1:0] word;
      logic [AW-1:0] a;
      word = '0;
      for (int k = 0; k < PK; k++) begin
        if (w * PK + k < n) word[k*DW +: DW] = DW'(model_vals[w * PK + k]);
      end
      a = base + AW'(w);
      exp_q.push_back({a, word});
    end
  endfunction

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_we && !we_seen) begin
        we_seen = 1'b1;
        first_we_cyc = cyc;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.mem_we && bus.mem_ready) begin
        if (exp_q.size() == 0) begin
          extra_writes++;
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check_eq("wr_addr", 64'(bus.mem_addr), 64'(e[EW-1:WW]));
          check_eq("wr_data", 64'(bus.mem_wdata), 64'(e[WW-1:0]));
        end
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
    end
  end

  // Random memory backpressure.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) bus.mem_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input int n);
    xfer_cnt = 0;
    extra_writes = 0;
    first_xfer_cyc = -1;
    last_xfer_cyc = -1;
    we_seen = 1'b0;
    busy_seen = 1'b0;
    done_base = done_cnt;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.num_vals = AW'(n);
    step();
    bus.start = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.num_vals = AW'($urandom);
  endtask

  task automatic drive_vals(input int gap_max, input bit bogus_start);
    for (int i = 0; i < stim_vals.size(); i++) begin
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) step();
      bus.in_valid = 1'b1;
      bus.in_data = DW'(stim_vals[i]);
      if (i == PK - 1) val_cyc = cyc;
      if (bogus_start && i == 0) begin
        bus.start = 1'b1;
        bus.num_vals = '0;
      end
      step();
      bus.in_valid = 1'b0;
      bus.start = 1'b0;
    end
  endtask

  task automatic finish_job(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 400) begin
      step();
      k++;
    end
    check_eq({tag, "_done_seen"}, 64'(done_cnt - done_base), 64'(1));
    check_eq({tag, "_done_one_cycle"}, 64'(bus.done), 64'(0));
    check_eq({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
    if (xfer_cnt > 0)
      check_eq({tag, "_done_latency"}, 64'(done_cyc), 64'(last_xfer_cyc + 1));
    check_eq({tag, "_words"}, 64'(xfer_cnt), 64'(exp_words));
    check_eq({tag, "_extra_writes"}, 64'(extra_writes), 64'(0));
    check_eq({tag, "_exp_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  function automatic int rand_act();
    return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
    check_eq({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    check_eq({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check_eq({tag, "_done"}, 64'(bus.done), 64'(0));
    check_eq({tag, "_overflow"}, 64'(bus.overflow), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.num_vals = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    ready_mode = 0;
    done_cnt = 0;
    xfer_cnt = 0;
    extra_writes = 0;
    we_seen = 1'b0;
    busy_seen = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    step();

    // Four values back to back, two words at 0x0100; stray value in IDLE.
    bus.in_valid = 1'b1;
    bus.in_data = DW'(777);
    step();
    bus.in_valid = 1'b0;
    stim_vals = '{1, 2, 3, 4};
    model_vals = stim_vals;
    build_expect(16'h0100);
    start_job(16'h0100, 4);
    drive_vals(0, 1'b0);
    finish_job("basic4");
    check_eq("basic4_we_latency", 64'(first_we_cyc), 64'(val_cyc + 2));

    // Odd count: final word zero-padded.
    stim_vals = '{-5, 7, 9};
    model_vals = stim_vals;
    build_expect(16'h0040);
    start_job(16'h0040, 3);
    drive_vals(0, 1'b0);
    finish_job("odd3");

    // Empty job: done next cycle, never busy, no write.
    stim_vals.delete();
    model_vals.delete();
    build_expect(16'h0000);
    start_job(16'h1234, 0);
    check_eq("empty_done_next", 64'(bus.done), 64'(1));
    finish_job("empty");
    check_eq("empty_busy_never", 64'(busy_seen), 64'(0));

    // Address wrap at the top of the address space.
    stim_vals.delete();
    for (int i = 0; i < 4; i++) stim_vals.push_back(rand_act());
    model_vals = stim_vals;
    build_expect(16'hFFFF);
    start_job(16'hFFFF, 4);
    drive_vals(1, 1'b0);
    finish_job("wrap");

    // Memory stalled for the whole stream: FD buffered plus one register
    // word survive, the rest are dropped; then one word per cycle.
    bus.mem_ready = 1'b0;
    stim_vals.delete();
    for (int i = 0; i < 20; i++) stim_vals.push_back(rand_act());
    model_vals.delete();
    for (int i = 0; i < FD + PK; i++) model_vals.push_back(stim_vals[i]);
    build_expect(16'h0200);
    start_job(16'h0200, 20);
    drive_vals(0, 1'b0);
    check_eq("stall_overflow", 64'(bus.overflow), 64'(1));
    check_eq("stall_no_xfer", 64'(xfer_cnt), 64'(0));
    check_eq("stall_we_held", 64'(bus.mem_we), 64'(1));
    step();
    step();
    bus.mem_ready = 1'b1;
    finish_job("stall");
    check_eq("stall_sustained", 64'(last_xfer_cyc - first_xfer_cyc), 64'(exp_words - 1));
    check_eq("stall_overflow_sticky", 64'(bus.overflow), 64'(1));

    // Randomized jobs with gaps, extra values, ignored starts, backpressure.
    ready_mode = 1;
    for (int j = 0; j < 10; j++) begin
      int n;
      int extra;
      logic [AW-1:0] base;
      n = $urandom_range(1, 12);
      extra = $urandom_range(0, 2);
      base = AW'($urandom);
      stim_vals.delete();
      for (int i = 0; i < n + extra; i++) stim_vals.push_back(rand_act());
      model_vals.delete();
      for (int i = 0; i < n; i++) model_vals.push_back(stim_vals[i]);
      build_expect(base);
      start_job(base, n);
      if (j == 0) check_eq("ovf_cleared_by_start", 64'(bus.overflow), 64'(0));
      drive_vals(2, n >= 2);
      finish_job("rand");
    end
    ready_mode = 0;
    step();

    // Reset in the middle of a job with a write pending.
    bus.mem_ready = 1'b0;
    stim_vals.delete();
    for (int i = 0; i < 20; i++) stim_vals.push_back(rand_act());
    start_job(16'h0300, 20);
    drive_vals(0, 1'b0);
    check_eq("abort_we_pre", 64'(bus.mem_we), 64'(1));
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_all_zero("abort");
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    step();

    // Normal job after the abort.
    stim_vals.delete();
    for (int i = 0; i < 5; i++) stim_vals.push_back(rand_act());
    model_vals = stim_vals;
    build_expect(16'h0400);
    start_job(16'h0400, 5);
    drive_vals(1, 1'b0);
    finish_job("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
